// File: rtl/ldpc_layer_sched_ctrl_if.sv
// ldpc_layer_sched_ctrl_if: control/status bundle between the decoder controller, the CNU/VNU datapath and the layer scheduler
interface ldpc_layer_sched_ctrl_if #(
    parameter int LAYER_NUM = 3,
    parameter int MAX_ITER  = 10
);
    localparam int LW = (LAYER_NUM > 1) ? $clog2(LAYER_NUM) : 1;
    localparam int IW = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;

    logic          fsm_en;
    logic          frame_start;
    logic          termination;
    logic          vnu_update_pend;
    logic          layer_finish;
    logic          syndrome_ok;
    logic          frame_ready;
    logic          de_frame_start;
    logic          decode_done;
    logic          early_term;
    logic          v2c_src;
    logic          cnu_rd;
    logic          c2v_mem_we;
    logic          last_layer;
    logic [LW-1:0] layer_idx;
    logic [IW-1:0] iter_idx;
    logic [3:0]    state;

    modport master (
        output fsm_en, frame_start, termination, vnu_update_pend, layer_finish, syndrome_ok,
        input  frame_ready, de_frame_start, decode_done, early_term, v2c_src, cnu_rd,
               c2v_mem_we, last_layer, layer_idx, iter_idx, state
    );

    modport slave (
        input  fsm_en, frame_start, termination, vnu_update_pend, layer_finish, syndrome_ok,
        output frame_ready, de_frame_start, decode_done, early_term, v2c_src, cnu_rd,
               c2v_mem_we, last_layer, layer_idx, iter_idx, state
    );
endinterface

// File: rtl/ldpc_layer_sched_ctrl.sv
// ldpc_layer_sched_ctrl: layered LDPC decoding sequencer (fetch, CNU, write-back, early termination)
module ldpc_layer_sched_ctrl #(
    parameter int LAYER_NUM          = 3,
    parameter int MAX_ITER           = 10,
    parameter int RESET_CYCLE        = 100,
    parameter int MEM_RD_LEVEL       = 2,
    parameter int CNU_PIPELINE_LEVEL = 4,
    parameter int PERMUTATION_LEVEL  = 2,
    parameter int PAGE_ALIGN_LEVEL   = 1,
    parameter bit EARLY_TERM_EN      = 1'b1
) (
    input logic                   read_clk,
    input logic                   rstn,
    ldpc_layer_sched_ctrl_if.slave bus
);
    localparam int LW = (LAYER_NUM > 1) ? $clog2(LAYER_NUM) : 1;
    localparam int IW = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;
    localparam int RW = (RESET_CYCLE > 0) ? $clog2(RESET_CYCLE + 1) : 1;

    // Stage counter reload values: the counter runs from N-1 down to 0 over an N-cycle state
    localparam int LD_MRD = MEM_RD_LEVEL - 1;
    localparam int LD_CNU = CNU_PIPELINE_LEVEL - 2;
    localparam int LD_BS  = PERMUTATION_LEVEL - 1;
    localparam int LD_PA  = (PAGE_ALIGN_LEVEL > 0) ? PAGE_ALIGN_LEVEL - 1 : 0;
    localparam int MX_A   = (LD_MRD > LD_CNU) ? LD_MRD : LD_CNU;
    localparam int MX_B   = (LD_BS > LD_PA) ? LD_BS : LD_PA;
    localparam int MX     = (MX_A > MX_B) ? MX_A : MX_B;
    localparam int CW     = (MX > 0) ? $clog2(MX + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_MEM_FETCH  = 4'd1,
        S_VNU_PEND   = 4'd2,
        S_CNU_PIPE   = 4'd3,
        S_CNU_OUT    = 4'd4,
        S_BS_WB      = 4'd5,
        S_PAGE_ALIGN = 4'd6,
        S_MEM_WB     = 4'd7,
        S_LAYER_WAIT = 4'd8,
        S_DONE       = 4'd9
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [LW-1:0] layer_q;
    logic [IW-1:0] iter_q;
    logic [RW-1:0] rst_cnt_q;
    logic          busy_q;
    logic          done_q;
    logic          et_q;

    logic rst_done;
    logic abort;
    logic cnt_last;
    logic is_last_layer;
    logic is_last_iter;
    logic syn_stop;

    assign rst_done      = (rst_cnt_q == RW'(RESET_CYCLE));
    assign abort         = bus.termination || !bus.fsm_en;
    assign cnt_last      = (cnt_q == '0);
    assign is_last_layer = (layer_q == LW'(LAYER_NUM - 1));
    assign is_last_iter  = (iter_q == IW'(MAX_ITER - 1));
    assign syn_stop      = EARLY_TERM_EN && bus.syndrome_ok;

    // Count cycles since reset release, saturating once the reset window has elapsed
    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            rst_cnt_q <= '0;
        end else if (!rst_done) begin
            rst_cnt_q <= rst_cnt_q + RW'(1);
        end
    end

    // Layer/iteration sequencer; abort (termination or fsm_en low) overrides every transition
    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            layer_q <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            et_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            et_q   <= 1'b0;
            if (abort) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                layer_q <= '0;
                iter_q  <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.frame_start && rst_done) begin
                            state_q <= S_MEM_FETCH;
                            cnt_q   <= CW'(LD_MRD);
                            layer_q <= '0;
                            iter_q  <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_MEM_FETCH: begin
                        if (!cnt_last) begin
                            cnt_q <= cnt_q - CW'(1);
                        end else if (bus.vnu_update_pend) begin
                            state_q <= S_VNU_PEND;
                        end else begin
                            state_q <= S_CNU_PIPE;
                            cnt_q   <= CW'(LD_CNU);
                        end
                    end
                    S_VNU_PEND: begin
                        if (!bus.vnu_update_pend) begin
                            state_q <= S_CNU_PIPE;
                            cnt_q   <= CW'(LD_CNU);
                        end
                    end
                    S_CNU_PIPE: begin
                        if (!cnt_last) begin
                            cnt_q <= cnt_q - CW'(1);
                        end else begin
                            state_q <= S_CNU_OUT;
                        end
                    end
                    S_CNU_OUT: begin
                        state_q <= S_BS_WB;
                        cnt_q   <= CW'(LD_BS);
                    end
                    S_BS_WB: begin
                        if (!cnt_last) begin
                            cnt_q <= cnt_q - CW'(1);
                        end else if (PAGE_ALIGN_LEVEL > 0) begin
                            state_q <= S_PAGE_ALIGN;
                            cnt_q   <= CW'(LD_PA);
                        end else begin
                            state_q <= S_MEM_WB;
                        end
                    end
                    S_PAGE_ALIGN: begin
                        if (!cnt_last) begin
                            cnt_q <= cnt_q - CW'(1);
                        end else begin
                            state_q <= S_MEM_WB;
                        end
                    end
                    S_MEM_WB: begin
                        state_q <= S_LAYER_WAIT;
                    end
                    S_LAYER_WAIT: begin
                        if (bus.layer_finish) begin
                            if (!is_last_layer) begin
                                state_q <= S_MEM_FETCH;
                                cnt_q   <= CW'(LD_MRD);
                                layer_q <= layer_q + LW'(1);
                            end else if (syn_stop || is_last_iter) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                et_q    <= syn_stop;
                            end else begin
                                state_q <= S_MEM_FETCH;
                                cnt_q   <= CW'(LD_MRD);
                                layer_q <= '0;
                                iter_q  <= iter_q + IW'(1);
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        layer_q <= '0;
                        iter_q  <= '0;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        layer_q <= '0;
                        iter_q  <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.frame_ready    = rst_done && (state_q == S_IDLE);
    assign bus.de_frame_start = busy_q;
    assign bus.decode_done    = done_q;
    assign bus.early_term     = et_q;
    assign bus.v2c_src        = (state_q == S_MEM_FETCH) && cnt_last;
    assign bus.cnu_rd         = (state_q == S_CNU_PIPE) || (state_q == S_CNU_OUT);
    assign bus.c2v_mem_we     = (state_q == S_MEM_WB);
    assign bus.last_layer     = is_last_layer;
    assign bus.layer_idx      = layer_q;
    assign bus.iter_idx       = iter_q;
    assign bus.state          = state_q;
endmodule
